// File: rtl/riscv_instr_mem_responder_if.sv
// Instruction-fetch bus between the core prefetch buffer and the responder,
// together with the responder's single-cycle SRAM read port.
interface riscv_instr_mem_responder_if #(
  parameter int MEM_AW = 14
);
  logic              instr_req_i;
  logic [31:0]       instr_addr_i;
  logic              instr_gnt_o;
  logic              instr_rvalid_o;
  logic [31:0]       instr_rdata_o;
  logic              stall_i;
  logic              mem_req_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic [31:0]       mem_rdata_i;

  modport slave (
    input  instr_req_i, instr_addr_i, stall_i, mem_rdata_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, mem_req_o, mem_addr_o
  );

  modport master (
    output instr_req_i, instr_addr_i, stall_i, mem_rdata_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/riscv_instr_mem_responder.sv
// Instruction memory responder: grants fetches into a one-cycle SRAM and returns
// words in order, buffering them in a small FIFO while responses are stalled.
module riscv_instr_mem_responder #(
  parameter int DEPTH  = 2,
  parameter int MEM_AW = 14
) (
  input  logic                         clk,
  input  logic                         rst,
  riscv_instr_mem_responder_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;
  logic          pend_q;

  logic          gnt;
  logic          rvalid;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [CW:0]   occupancy;
  logic          unused_addr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Occupancy counts the word still in flight from the SRAM, so a grant is only
  // issued when a slot is guaranteed for its data even if delivery is stalled.
  always_comb begin
    fifo_empty = (fifo_count == '0);
    occupancy  = {1'b0, fifo_count} + (CW + 1)'(pend_q);
    gnt        = !rst && bus.instr_req_i && (occupancy < (CW + 1)'(DEPTH));
    rvalid     = !bus.stall_i && (!fifo_empty || pend_q);
    pop        = rvalid && !fifo_empty;
    push       = pend_q && !(rvalid && fifo_empty);
  end

  assign bus.instr_gnt_o    = gnt;
  assign bus.mem_req_o      = gnt;
  assign bus.mem_addr_o     = rst ? '0 : bus.instr_addr_i[MEM_AW+1:2];
  assign bus.instr_rvalid_o = rvalid;
  assign bus.instr_rdata_o  = !rvalid    ? 32'h0 :
                              fifo_empty ? bus.mem_rdata_i : fifo_mem[rd_ptr];
  assign unused_addr = ^{bus.instr_addr_i[31:MEM_AW+2], bus.instr_addr_i[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      pend_q <= gnt;
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.mem_rdata_i;
  end
endmodule

// File: tb/tb_riscv_instr_mem_responder.sv
// Directed self-checking bench for riscv_instr_mem_responder with a one-cycle
// SRAM model; expected words come from the bench's own address-to-data function.
module tb_riscv_instr_mem_responder;
  localparam int DEPTH  = 2;
  localparam int MEM_AW = 14;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic overflow_seen;
  logic underflow_seen;

  riscv_instr_mem_responder_if #(.MEM_AW(MEM_AW)) bus ();

  riscv_instr_mem_responder #(.DEPTH(DEPTH), .MEM_AW(MEM_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sram_word(input logic [MEM_AW-1:0] a);
    return (a == 14'h040) ? 32'h0000_0013 : (32'hD000_0000 | {18'b0, a});
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] byte_addr);
    return sram_word(byte_addr[MEM_AW+1:2]);
  endfunction

  // One-cycle read-latency SRAM
  always @(posedge clk) begin
    if (bus.mem_req_o) bus.mem_rdata_i <= sram_word(bus.mem_addr_o);
  end

  always @(negedge clk) begin
    if (dut.push && dut.fifo_count == DEPTH) overflow_seen = 1'b1;
    if (dut.pop && dut.fifo_count == 0)      underflow_seen = 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic req, input logic [31:0] addr,
                               input logic stall);
    @(posedge clk);
    #1;
    rst              = r;
    bus.instr_req_i  = req;
    bus.instr_addr_i = addr;
    bus.stall_i      = stall;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int           granted;
    int           received;
    logic [31:0]  na;

    clk = 1'b0; rst = 1'b1; total = 0; bad = 0;
    overflow_seen = 1'b0; underflow_seen = 1'b0;
    bus.instr_req_i = 1'b0; bus.instr_addr_i = 32'h0; bus.stall_i = 1'b0;

    // Reset holds every output low even with a request present
    applyStimulus(1'b1, 1'b1, 32'h0000_0104, 1'b0);
    checkOutput("rst_gnt",      32'(bus.instr_gnt_o),    32'h0);
    checkOutput("rst_rvalid",   32'(bus.instr_rvalid_o), 32'h0);
    checkOutput("rst_rdata",    bus.instr_rdata_o,       32'h0);
    checkOutput("rst_mem_req",  32'(bus.mem_req_o),      32'h0);
    checkOutput("rst_mem_addr", 32'(bus.mem_addr_o),     32'h0);

    // Single fetch in the first cycle after reset, bypass return next cycle
    applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b0);
    checkOutput("single_gnt",      32'(bus.instr_gnt_o),    32'h1);
    checkOutput("single_mem_req",  32'(bus.mem_req_o),      32'h1);
    checkOutput("single_mem_addr", 32'(bus.mem_addr_o),     32'h40);
    checkOutput("single_rvalid0",  32'(bus.instr_rvalid_o), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("single_rvalid1",  32'(bus.instr_rvalid_o), 32'h1);
    checkOutput("single_rdata",    bus.instr_rdata_o,       32'h0000_0013);
    checkOutput("single_gnt_idle", 32'(bus.instr_gnt_o),    32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("single_rvalid2",  32'(bus.instr_rvalid_o), 32'h0);
    checkOutput("single_rdata_z",  bus.instr_rdata_o,       32'h0);

    // Byte offset bits are ignored
    applyStimulus(1'b0, 1'b1, 32'h0000_0102, 1'b0);
    checkOutput("lowbits_gnt",  32'(bus.instr_gnt_o), 32'h1);
    checkOutput("lowbits_addr", 32'(bus.mem_addr_o),  32'h40);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("lowbits_rvalid", 32'(bus.instr_rvalid_o), 32'h1);
    checkOutput("lowbits_rdata",  bus.instr_rdata_o,       32'h0000_0013);

    // Eight back-to-back fetches
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 32'(i * 4), 1'b0);
      checkOutput("burst_gnt", 32'(bus.instr_gnt_o), 32'h1);
      if (i > 0) begin
        checkOutput("burst_rvalid", 32'(bus.instr_rvalid_o), 32'h1);
        checkOutput("burst_rdata",  bus.instr_rdata_o,       exp_word(32'((i - 1) * 4)));
      end else begin
        checkOutput("burst_rvalid_first", 32'(bus.instr_rvalid_o), 32'h0);
      end
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("burst_last_rvalid", 32'(bus.instr_rvalid_o), 32'h1);
    checkOutput("burst_last_rdata",  bus.instr_rdata_o,       exp_word(32'h1C));
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("burst_drained", 32'(bus.instr_rvalid_o), 32'h0);

    // Stall with request held: two grants fill the FIFO, then grant stays low
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b1, (k < 2) ? 32'(32'h200 + 4 * k) : 32'h208, 1'b1);
      checkOutput("stall_gnt",    32'(bus.instr_gnt_o),    (k < 2) ? 32'h1 : 32'h0);
      checkOutput("stall_rvalid", 32'(bus.instr_rvalid_o), 32'h0);
    end
    applyStimulus(1'b0, 1'b1, 32'h208, 1'b0);
    checkOutput("unstall0_rvalid", 32'(bus.instr_rvalid_o), 32'h1);
    checkOutput("unstall0_rdata",  bus.instr_rdata_o,       exp_word(32'h200));
    checkOutput("unstall0_gnt",    32'(bus.instr_gnt_o),    32'h0);
    applyStimulus(1'b0, 1'b1, 32'h208, 1'b0);
    checkOutput("unstall1_rvalid", 32'(bus.instr_rvalid_o), 32'h1);
    checkOutput("unstall1_rdata",  bus.instr_rdata_o,       exp_word(32'h204));
    checkOutput("unstall1_gnt",    32'(bus.instr_gnt_o),    32'h1);
    applyStimulus(1'b0, 1'b1, 32'h20C, 1'b0);
    checkOutput("unstall2_rdata",  bus.instr_rdata_o,       exp_word(32'h208));
    checkOutput("unstall2_gnt",    32'(bus.instr_gnt_o),    32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("unstall3_rdata",  bus.instr_rdata_o,       exp_word(32'h20C));
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("unstall_drained", 32'(bus.instr_rvalid_o), 32'h0);

    // Stall toggling every cycle over 100 sequential fetches
    granted = 0; received = 0; na = 32'h400;
    for (int c = 0; c < 1000 && received < 100; c++) begin
      applyStimulus(1'b0, granted < 100, na, c[0]);
      if (bus.instr_gnt_o) begin
        granted++;
        na += 32'h4;
      end
      if (bus.instr_rvalid_o) begin
        checkOutput("toggle_rdata", bus.instr_rdata_o, exp_word(32'h400 + 32'(4 * received)));
        received++;
      end
    end
    checkOutput("toggle_received", 32'(received), 32'd100);
    checkOutput("toggle_granted",  32'(granted),  32'd100);
    for (int j = 0; j < 2; j++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("toggle_extra_rvalid", 32'(bus.instr_rvalid_o), 32'h0);
    end

    // Reset while FIFO holds a word and another is in flight
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b1);
    checkOutput("midrst_gnt0", 32'(bus.instr_gnt_o), 32'h1);
    applyStimulus(1'b0, 1'b1, 32'h304, 1'b1);
    checkOutput("midrst_gnt1", 32'(bus.instr_gnt_o), 32'h1);
    applyStimulus(1'b1, 1'b1, 32'h308, 1'b0);
    checkOutput("midrst_gnt",      32'(bus.instr_gnt_o),    32'h0);
    checkOutput("midrst_rvalid",   32'(bus.instr_rvalid_o), 32'h0);
    checkOutput("midrst_rdata",    bus.instr_rdata_o,       32'h0);
    checkOutput("midrst_mem_req",  32'(bus.mem_req_o),      32'h0);
    checkOutput("midrst_mem_addr", 32'(bus.mem_addr_o),     32'h0);
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("postrst_rvalid", 32'(bus.instr_rvalid_o), 32'h0);
    end
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b0);
    checkOutput("postrst_gnt", 32'(bus.instr_gnt_o), 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("postrst_rvalid1", 32'(bus.instr_rvalid_o), 32'h1);
    checkOutput("postrst_rdata",   bus.instr_rdata_o,       32'h0000_0013);

    checkOutput("no_push_full",  32'(overflow_seen),  32'h0);
    checkOutput("no_pop_empty",  32'(underflow_seen), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
